// File: rtl/exec_pkg.sv
// Shared types for the execute unit: opcodes, FSM states and the immediate sign-extension helper.
package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_SUB  = 3'd2,
    OP_NAND = 3'd3,
    OP_BNE  = 3'd4,
    OP_LW   = 3'd5,
    OP_SW   = 3'd6,
    OP_J    = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned SEXT_MAX_W = 64;

  // Sign-extends the low w bits of v to SEXT_MAX_W; callers cast down to their own width.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] v,
                                                 input int unsigned w);
    logic signed [SEXT_MAX_W-1:0] t;
    t = $signed(v << (SEXT_MAX_W - w));
    return t >>> (SEXT_MAX_W - w);
  endfunction

endpackage

// File: rtl/exec_apb_master.sv
// APB master for LW/SW: SETUP/ACCESS sequencing and registered APB outputs.
// Optional ACCESS-phase abort counter is compiled in with EXEC_APB_TIMEOUT_EN.
module exec_apb_master
  import exec_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              rsp,
  output logic [WIDTH-1:0]  rdata,
  output logic              rerr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [WIDTH-1:0]  pwdata,
  input  logic [WIDTH-1:0]  prdata,
  input  logic              pready,
  input  logic              pslverr
);

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [WIDTH-1:0]  pwdata_q, pwdata_d;
  logic              in_setup, in_access, timeout;

  assign in_setup  = psel_q & ~penable_q;
  assign in_access = psel_q & penable_q;

`ifdef EXEC_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Abort at the end of the TIMEOUT-th stalled ACCESS cycle; pready in that cycle still wins.
  assign timeout = in_access & ~pready & (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (in_setup) begin
      cnt_d = '0;
    end else if (in_access && !pready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign rsp   = in_access & (pready | timeout);
  assign rdata = prdata;
  assign rerr  = pready ? pslverr : 1'b1;

  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (req) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = wr;
      paddr_d   = addr;
      pwdata_d  = wdata;
    end else if (in_setup) begin
      penable_d = 1'b1;
    end else if (rsp) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: rtl/exec_unit.sv
// Execute unit: ALU ops complete in one cycle, LW/SW run as APB transfers via exec_apb_master.
// EXEC_APB_TIMEOUT_EN enables the APB ACCESS-phase timeout abort.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 16,
  parameter int IMM_W   = 7,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  op_t               op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [IMM_W-1:0]  imm,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [WIDTH-1:0]  pwdata,
  input  logic [WIDTH-1:0]  prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] imm_ext, sum_imm, alu_res;
  logic             accept, is_mem, req, rsp, rerr;
  logic [WIDTH-1:0] rdata;

  assign imm_ext = WIDTH'(sext(SEXT_MAX_W'(imm), IMM_W));
  assign sum_imm = a + imm_ext;
  assign accept  = start & ((state_q == IDLE) | (state_q == DONE));
  assign is_mem  = (op == OP_LW) | (op == OP_SW);
  assign req     = accept & is_mem;

  always_comb begin
    alu_res = sum_imm;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_NAND: alu_res = ~(a & b);
      default: alu_res = sum_imm;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          op_d = op;
          if (is_mem) begin
            state_d = SETUP;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (rsp) begin
          state_d = DONE;
          err_d   = rerr;
          // A timeout abort (no pready) leaves the previous result in place.
          if (op_q == OP_LW && pready) begin
            result_d = rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  exec_apb_master #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_apb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .wr      (op == OP_SW),
    .addr    (sum_imm[ADDR_W-1:0]),
    .wdata   (b),
    .rsp     (rsp),
    .rdata   (rdata),
    .rerr    (rerr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  assign result = result_q;
  assign err    = err_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q == SETUP) | (state_q == ACCESS);

endmodule

// File: tb/tb_exec_unit.sv
// Randomized bench for exec_unit with a transaction-level reference model and an APB slave.
module tb_exec_unit;
  import exec_pkg::*;

  localparam int TO = 15;
`ifdef EXEC_APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  op_t         op;
  logic [15:0] a, b;
  logic [6:0]  imm;
  logic [15:0] result;
  logic        done, busy, err;
  logic        psel, penable, pwrite;
  logic [15:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] model_res = 16'h0;

  always #5 clk = ~clk;

  exec_unit #(.WIDTH(16), .ADDR_W(16), .IMM_W(7), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b), .imm(imm),
    .result(result), .done(done), .busy(busy), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int simm(input logic [6:0] i);
    int s;
    s = int'(i);
    if (s >= 64) s = s - 128;
    return s;
  endfunction

  // Issues one op just after a negedge and follows it to its done cycle.
  task automatic do_op(input int opc, input logic [15:0] av, input logic [15:0] bv,
                       input logic [6:0] iv, input int waits, input logic [15:0] rd,
                       input logic se, input bit gap);
    logic [15:0] ea;
    bit is_mem, abort;
    int nacc;
    start = 1'b1; op = op_t'(3'(opc)); a = av; b = bv; imm = iv;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); imm = 7'($urandom);
    op = op_t'(3'($urandom));
    ea = 16'(int'(av) + simm(iv));
    is_mem = (opc == 5) || (opc == 6);
    if (!is_mem) begin
      case (opc)
        0: model_res = av + bv;
        2: model_res = av - bv;
        3: model_res = ~(av & bv);
        default: model_res = ea;
      endcase
      @(negedge clk);
      check("alu_done", 32'(done), 32'd1);
      check("alu_result", 32'(result), 32'(model_res));
      check("alu_err", 32'(err), 32'd0);
      check("alu_busy", 32'(busy), 32'd0);
    end else begin
      @(negedge clk);
      check("setup_psel", 32'(psel), 32'd1);
      check("setup_penable", 32'(penable), 32'd0);
      check("setup_pwrite", 32'(pwrite), 32'(opc == 6));
      check("setup_paddr", 32'(paddr), 32'(ea));
      check("setup_busy", 32'(busy), 32'd1);
      if (opc == 6) check("setup_pwdata", 32'(pwdata), 32'(bv));
      abort = TO_EN && (waits >= TO);
      nacc = abort ? TO : waits + 1;
      for (int k = 1; k <= nacc; k++) begin
        @(posedge clk); #1;
        pready  = (k == waits + 1);
        prdata  = (k == waits + 1) ? rd : 16'($urandom);
        pslverr = (k == waits + 1) ? se : 1'($urandom);
        start   = 1'($urandom);
        op      = OP_ADD;
        @(negedge clk);
        check("access_psel", 32'(psel), 32'd1);
        check("access_penable", 32'(penable), 32'd1);
        check("access_paddr", 32'(paddr), 32'(ea));
        check("access_pwrite", 32'(pwrite), 32'(opc == 6));
        check("access_done", 32'(done), 32'd0);
        if (opc == 6) check("access_pwdata", 32'(pwdata), 32'(bv));
      end
      @(posedge clk); #1;
      pready = 1'b0; pslverr = 1'b0; start = 1'b0;
      if (opc == 5 && !abort) model_res = rd;
      @(negedge clk);
      check("mem_done", 32'(done), 32'd1);
      check("mem_psel", 32'(psel), 32'd0);
      check("mem_penable", 32'(penable), 32'd0);
      check("mem_err", 32'(err), abort ? 32'd1 : 32'(se));
      check("mem_result", 32'(result), 32'(model_res));
      check("mem_busy", 32'(busy), 32'd0);
    end
    if (gap) begin
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic reset_mid_access();
    start = 1'b1; op = OP_LW; a = 16'h0200; b = 16'h0; imm = 7'h01;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    pready = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_res = 16'h0;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_no_done_after", 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = OP_ADD; a = '0; b = '0; imm = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #3;
    check("reset_result", 32'(result), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_apb", 32'({psel, penable, pwrite}), 32'd0);
    check("reset_paddr", 32'(paddr), 32'd0);
    check("reset_pwdata", 32'(pwdata), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(0, 16'hFFFF, 16'h0002, 7'h00, 0, 16'h0, 1'b0, 1'b0);
    do_op(1, 16'h0010, 16'h0000, 7'h7E, 0, 16'h0, 1'b0, 1'b0);
    do_op(3, 16'hF0F0, 16'hFF00, 7'h00, 0, 16'h0, 1'b0, 1'b1);
    do_op(5, 16'h0100, 16'h0000, 7'h04, 2, 16'hBEEF, 1'b0, 1'b1);
    do_op(6, 16'h0300, 16'h1234, 7'h7F, 0, 16'h0, 1'b1, 1'b1);
    do_op(5, 16'h0400, 16'h0000, 7'h40, 20, 16'hCAFE, 1'b0, 1'b1);
    if (TO_EN) begin
      do_op(5, 16'h0500, 16'h0000, 7'h02, 30, 16'h1111, 1'b0, 1'b1);
      do_op(5, 16'h0600, 16'h0000, 7'h02, TO - 1, 16'h2222, 1'b0, 1'b1);
    end

    for (int n = 0; n < 200; n++) begin
      int oc, w;
      oc = int'($urandom_range(0, 7));
      w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 3));
      do_op(oc, 16'($urandom), 16'($urandom), 7'($urandom), w, 16'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    reset_mid_access();
    do_op(0, 16'h1000, 16'h0234, 7'h00, 0, 16'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
